// File: rtl/inst_decode_pipe_pkg.sv
// Shared decode types and the combinational RV32I decoder used ahead of the pipe.
// Holds opcode/arith/branch enums, per-unit control structs and immediate formation.
package corePckg;

  localparam int cXLen = 32;

  typedef enum logic [6:0] {
    eOpLoad    = 7'b0000011,
    eOpMiscMem = 7'b0001111,
    eOpImm     = 7'b0010011,
    eOpAuipc   = 7'b0010111,
    eOpStore   = 7'b0100011,
    eOpReg     = 7'b0110011,
    eOpLui     = 7'b0110111,
    eOpBranch  = 7'b1100011,
    eOpJalr    = 7'b1100111,
    eOpJal     = 7'b1101111,
    eOpSystem  = 7'b1110011
  } tOpcodeEnum;

  typedef enum logic [3:0] {
    eNoOp, eAdd, eSub, eShftLeft, eSetLess, eSetLessU,
    eXor, eShftRight, eShftRightArit, eOr, eAnd
  } tArithEnum;

  typedef enum logic [3:0] {
    eNoBranch, eEqual, eNotEqual, eLess, eGreaterEq, eLessU, eGreaterEqU, eJal, eJalr
  } tBranchEnum;

  typedef enum logic [2:0] {eImmI, eImmS, eImmB, eImmU, eImmJ, eImmNone} tImmFmt;

  typedef struct packed {
    tOpcodeEnum        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [cXLen-1:0]  imm;
    logic [cXLen-1:0]  curPc;
  } tDecodedInst;

  typedef struct packed {
    logic       dv;
    logic       isLoad;
    logic       isStore;
    logic [2:0] size;
  } tDecodedMemOp;

  typedef struct packed {
    logic      dv;
    tArithEnum arith;
    logic      opRs1;
    logic      opRs2;
    logic      opImm;
    logic      opPc;
    logic      opConst;
  } tDecodedRegOp;

  typedef struct packed {
    logic       dv;
    tBranchEnum branch;
  } tDecodedBranchOp;

  typedef struct packed {
    logic            illegal;
    tDecodedBranchOp branchOp;
    tDecodedRegOp    regOp;
    tDecodedMemOp    memOp;
    tDecodedInst     dec;
  } tDecodeBundle;

  function automatic logic [cXLen-1:0] immGen(input logic [31:0] inst, input tImmFmt fmt);
    logic [cXLen-1:0] imm;
    case (fmt)
      eImmI:   imm = {{20{inst[31]}}, inst[31:20]};
      eImmS:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      eImmB:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      eImmU:   imm = {inst[31:12], 12'b0};
      eImmJ:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // alt selects SUB / arithmetic right shift where funct3 allows it
  function automatic tArithEnum arithFromF3(input logic [2:0] f3, input logic alt);
    tArithEnum a;
    case (f3)
      3'b000:  a = alt ? eSub : eAdd;
      3'b001:  a = eShftLeft;
      3'b010:  a = eSetLess;
      3'b011:  a = eSetLessU;
      3'b100:  a = eXor;
      3'b101:  a = alt ? eShftRightArit : eShftRight;
      3'b110:  a = eOr;
      default: a = eAnd;
    endcase
    return a;
  endfunction

  function automatic tDecodeBundle decodeInst(input logic [31:0] inst, input logic [31:0] pc,
                                              input logic fenceAsNop);
    tDecodeBundle b;
    tImmFmt       fmt;
    logic         ill;
    logic [2:0]   f3;
    logic [6:0]   f7;
    b   = '0;
    fmt = eImmNone;
    ill = 1'b0;
    f3  = inst[14:12];
    f7  = inst[31:25];
    b.dec.opcode = tOpcodeEnum'(inst[6:0]);
    b.dec.rd     = inst[11:7];
    b.dec.rs1    = inst[19:15];
    b.dec.rs2    = inst[24:20];
    b.dec.funct3 = f3;
    b.dec.funct7 = f7;
    b.dec.curPc  = pc;
    case (inst[6:0])
      eOpLoad: begin
        fmt = eImmI;
        b.memOp = '{dv: 1'b1, isLoad: 1'b1, isStore: 1'b0, size: f3};
        b.regOp = '{dv: 1'b1, arith: eAdd, opRs1: 1'b1, opRs2: 1'b0, opImm: 1'b1, opPc: 1'b0, opConst: 1'b0};
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      eOpStore: begin
        fmt = eImmS;
        b.memOp = '{dv: 1'b1, isLoad: 1'b0, isStore: 1'b1, size: f3};
        b.regOp = '{dv: 1'b1, arith: eAdd, opRs1: 1'b1, opRs2: 1'b0, opImm: 1'b1, opPc: 1'b0, opConst: 1'b0};
        ill = f3[2] || (f3 == 3'b011);
      end
      eOpImm: begin
        fmt = eImmI;
        b.regOp = '{dv: 1'b1, arith: arithFromF3(f3, (f3 == 3'b101) && f7[5]),
                    opRs1: 1'b1, opRs2: 1'b0, opImm: 1'b1, opPc: 1'b0, opConst: 1'b0};
        ill = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
              ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
      end
      eOpReg: begin
        b.regOp = '{dv: 1'b1, arith: arithFromF3(f3, f7[5]),
                    opRs1: 1'b1, opRs2: 1'b1, opImm: 1'b0, opPc: 1'b0, opConst: 1'b0};
        ill = ((f7 != 7'b0000000) && (f7 != 7'b0100000)) ||
              ((f7 == 7'b0100000) && (f3 != 3'b000) && (f3 != 3'b101));
      end
      eOpLui: begin
        fmt = eImmU;
        b.regOp = '{dv: 1'b1, arith: eNoOp, opRs1: 1'b0, opRs2: 1'b0, opImm: 1'b1, opPc: 1'b0, opConst: 1'b0};
      end
      eOpAuipc: begin
        fmt = eImmU;
        b.regOp = '{dv: 1'b1, arith: eAdd, opRs1: 1'b0, opRs2: 1'b0, opImm: 1'b1, opPc: 1'b1, opConst: 1'b0};
      end
      eOpJal, eOpJalr: begin
        fmt = (inst[6:0] == eOpJal) ? eImmJ : eImmI;
        // link value is pc + constant 4; target is formed by the branch unit
        b.regOp    = '{dv: 1'b1, arith: eAdd, opRs1: 1'b0, opRs2: 1'b0, opImm: 1'b0, opPc: 1'b1, opConst: 1'b1};
        b.branchOp = '{dv: 1'b1, branch: (inst[6:0] == eOpJal) ? eJal : eJalr};
      end
      eOpBranch: begin
        fmt = eImmB;
        b.branchOp.dv = 1'b1;
        case (f3)
          3'b000:  b.branchOp.branch = eEqual;
          3'b001:  b.branchOp.branch = eNotEqual;
          3'b100:  b.branchOp.branch = eLess;
          3'b101:  b.branchOp.branch = eGreaterEq;
          3'b110:  b.branchOp.branch = eLessU;
          3'b111:  b.branchOp.branch = eGreaterEqU;
          default: ill = 1'b1;
        endcase
      end
      eOpMiscMem: ill = !fenceAsNop;
      default:    ill = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) ill = 1'b1;
    b.dec.imm = immGen(inst, fmt);
    if (ill) begin
      b.memOp    = '0;
      b.regOp    = '0;
      b.branchOp = '0;
      b.dec.imm  = '0;
    end
    b.illegal = ill;
    return b;
  endfunction

endpackage

// File: rtl/inst_decode_pipe_slice.sv
// One valid/ready register stage carrying an opaque payload.
// Loads when empty or when downstream takes the current entry; flush clears the valid bit.
module dec_pipe_slice #(
  parameter int pWidth = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iFlush,
  input  logic              iValid,
  output logic              oReady,
  input  logic [pWidth-1:0] iData,
  output logic              oValid,
  input  logic              iReady,
  output logic [pWidth-1:0] oData
);

  logic              validQ;
  logic [pWidth-1:0] dataQ;

  assign oReady = !validQ || iReady;
  assign oValid = validQ;
  assign oData  = dataQ;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      validQ <= 1'b0;
      dataQ  <= '0;
    end else begin
      if (iFlush)      validQ <= 1'b0;
      else if (oReady) validQ <= iValid;
      if (oReady && iValid && !iFlush) dataQ <= iData;
    end
  end

endmodule

// File: rtl/inst_decode_pipe.sv
// RV32I decode followed by pStages valid/ready register slices (latency pStages, 1/cycle).
// Decode is combinational on the input; the slices only carry the decoded bundle.
module inst_decode_pipe
  import corePckg::*;
#(
  parameter int pXLEN       = 32,
  parameter int pStages     = 2,
  parameter int pFenceAsNop = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [pXLEN-1:0] iInst,
  input  logic [pXLEN-1:0] iCurPc,
  input  logic             iValid,
  output logic             oReady,
  input  logic             iFlush,
  output logic             oValid,
  input  logic             iReady,
  output tDecodedInst      oDecoded,
  output tDecodedMemOp     oMemOp,
  output tDecodedRegOp     oRegOp,
  output tDecodedBranchOp  oBranchOp,
  output logic             oIllegal
);

  localparam int cBundleW = $bits(tDecodeBundle);

  logic [pStages:0]    vldChain;
  logic [pStages:0]    rdyChain;
  logic [cBundleW-1:0] dataChain [pStages+1];
  tDecodeBundle        decIn;
  tDecodeBundle        decOut;

  always_comb decIn = decodeInst(iInst, iCurPc, pFenceAsNop != 0);

  assign vldChain[0]       = iValid;
  assign dataChain[0]      = decIn;
  assign oReady            = rdyChain[0];
  assign rdyChain[pStages] = iReady;

  for (genvar k = 0; k < pStages; k++) begin : gStage
    dec_pipe_slice #(.pWidth(cBundleW)) uSlice (
      .iClk   (iClk),
      .iRst   (iRst),
      .iFlush (iFlush),
      .iValid (vldChain[k]),
      .oReady (rdyChain[k]),
      .iData  (dataChain[k]),
      .oValid (vldChain[k+1]),
      .iReady (rdyChain[k+1]),
      .oData  (dataChain[k+1])
    );
  end

  assign decOut    = tDecodeBundle'(dataChain[pStages]);
  assign oValid    = vldChain[pStages];
  assign oDecoded  = decOut.dec;
  assign oMemOp    = decOut.memOp;
  assign oRegOp    = decOut.regOp;
  assign oBranchOp = decOut.branchOp;
  assign oIllegal  = decOut.illegal;

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Directed bench for inst_decode_pipe (pStages=2, FENCE as NOP).
module tb_inst_decode_pipe;
  import corePckg::*;

  logic            iClk = 1'b0;
  logic            iRst, iValid, iReady, iFlush;
  logic [31:0]     iInst, iCurPc;
  logic            oReady, oValid, oIllegal;
  tDecodedInst     oDecoded;
  tDecodedMemOp    oMemOp;
  tDecodedRegOp    oRegOp;
  tDecodedBranchOp oBranchOp;

  int tests = 0;
  int fails = 0;

  always #5 iClk = ~iClk;

  inst_decode_pipe #(.pXLEN(32), .pStages(2), .pFenceAsNop(1)) dut (
    .iClk(iClk), .iRst(iRst), .iInst(iInst), .iCurPc(iCurPc), .iValid(iValid),
    .oReady(oReady), .iFlush(iFlush), .oValid(oValid), .iReady(iReady),
    .oDecoded(oDecoded), .oMemOp(oMemOp), .oRegOp(oRegOp), .oBranchOp(oBranchOp),
    .oIllegal(oIllegal)
  );

  task automatic step;
    @(posedge iClk);
    #1;
  endtask

  // Push one word into an empty pipe with iReady=1; returns with it at the output.
  task automatic sendOne(input logic [31:0] inst, input logic [31:0] pc);
    iInst = inst; iCurPc = pc; iValid = 1'b1;
    step;
    iValid = 1'b0; iInst = '0;
    step;
  endtask

  task automatic test_reset;
    iRst = 1'b1; iValid = 1'b0; iReady = 1'b1; iFlush = 1'b0; iInst = '0; iCurPc = '0;
    step; step;
    tests++; if (oValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", oValid); end
    tests++; if (oIllegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b want 0", oIllegal); end
    tests++; if (oDecoded !== '0) begin fails++; $display("FAIL reset_payload: got %h want 0", oDecoded); end
    iRst = 1'b0;
    step;
    tests++; if (oReady !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", oReady); end
  endtask

  task automatic test_addi;
    iInst = 32'hFFF10093; iCurPc = 32'h100; iValid = 1'b1;
    step;
    iValid = 1'b0;
    tests++; if (oValid !== 1'b0) begin fails++; $display("FAIL addi_lat1: got %b want 0", oValid); end
    step;
    tests++; if (oValid !== 1'b1) begin fails++; $display("FAIL addi_lat2: got %b want 1", oValid); end
    tests++; if (oDecoded.rd !== 5'd1 || oDecoded.rs1 !== 5'd2) begin fails++;
      $display("FAIL addi_regs: got rd=%0d rs1=%0d want 1 2", oDecoded.rd, oDecoded.rs1); end
    tests++; if (oDecoded.imm !== 32'hFFFFFFFF) begin fails++; $display("FAIL addi_imm: got %h want ffffffff", oDecoded.imm); end
    tests++; if (oRegOp.arith !== eAdd || oRegOp.opRs1 !== 1'b1 || oRegOp.opImm !== 1'b1 || oRegOp.dv !== 1'b1) begin fails++;
      $display("FAIL addi_regop: got %h want add/rs1/imm", oRegOp); end
    tests++; if (oDecoded.curPc !== 32'h100 || oIllegal !== 1'b0) begin fails++;
      $display("FAIL addi_pc: got pc=%h ill=%b want 100 0", oDecoded.curPc, oIllegal); end
    step;
    tests++; if (oValid !== 1'b0) begin fails++; $display("FAIL addi_nodup: got %b want 0", oValid); end
  endtask

  task automatic test_shift;
    logic [31:0] imm;
    sendOne(32'h40315093, 32'h104);
    imm = oDecoded.imm;
    tests++; if (oRegOp.arith !== eShftRightArit || imm[4:0] !== 5'd3) begin fails++;
      $display("FAIL srai: got arith=%0d sh=%0d want %0d 3", oRegOp.arith, imm[4:0], eShftRightArit); end
    step;
    sendOne(32'h00315093, 32'h108);
    imm = oDecoded.imm;
    tests++; if (oRegOp.arith !== eShftRight || imm[4:0] !== 5'd3) begin fails++;
      $display("FAIL srli: got arith=%0d sh=%0d want %0d 3", oRegOp.arith, imm[4:0], eShftRight); end
    step;
  endtask

  task automatic test_branch;
    sendOne(32'hFE000EE3, 32'h10C);
    tests++; if (oDecoded.imm !== 32'hFFFFFFFC) begin fails++; $display("FAIL beq_imm: got %h want fffffffc", oDecoded.imm); end
    tests++; if (oBranchOp.branch !== eEqual || oBranchOp.dv !== 1'b1 || oIllegal !== 1'b0) begin fails++;
      $display("FAIL beq_op: got %h ill=%b want eEqual dv=1", oBranchOp, oIllegal); end
    step;
  endtask

  task automatic test_misc;
    sendOne(32'h123450B7, 32'h200);  // LUI x1,0x12345
    tests++; if (oDecoded.imm !== 32'h12345000 || oRegOp.arith !== eNoOp || oRegOp.opImm !== 1'b1 || oRegOp.dv !== 1'b1) begin fails++;
      $display("FAIL lui: got imm=%h regop=%h", oDecoded.imm, oRegOp); end
    step;
    sendOne(32'h008000EF, 32'h204);  // JAL x1,+8
    tests++; if (oDecoded.imm !== 32'h8 || oRegOp.arith !== eAdd || oRegOp.opPc !== 1'b1 || oRegOp.opConst !== 1'b1) begin fails++;
      $display("FAIL jal_reg: got imm=%h regop=%h", oDecoded.imm, oRegOp); end
    tests++; if (oBranchOp.branch !== eJal || oBranchOp.dv !== 1'b1) begin fails++; $display("FAIL jal_br: got %h want eJal dv=1", oBranchOp); end
    step;
    sendOne(32'h0FF0000F, 32'h208);  // FENCE
    tests++; if (oIllegal !== 1'b0 || oRegOp.dv !== 1'b0 || oMemOp.dv !== 1'b0 || oBranchOp.dv !== 1'b0) begin fails++;
      $display("FAIL fence: got ill=%b dv=%b%b%b want 0 000", oIllegal, oRegOp.dv, oMemOp.dv, oBranchOp.dv); end
    step;
    sendOne(32'h0020A423, 32'h20C);  // SW x2,8(x1)
    tests++; if (oDecoded.imm !== 32'h8 || oMemOp.dv !== 1'b1 || oMemOp.isStore !== 1'b1 || oDecoded.rs2 !== 5'd2) begin fails++;
      $display("FAIL sw: got imm=%h memop=%h rs2=%0d", oDecoded.imm, oMemOp, oDecoded.rs2); end
    step;
    sendOne(32'h00000073, 32'h210);  // ECALL
    tests++; if (oIllegal !== 1'b1 || oValid !== 1'b1) begin fails++; $display("FAIL ecall: got ill=%b vld=%b want 1 1", oIllegal, oValid); end
    step;
    sendOne(32'h0000B003, 32'h214);  // load funct3=011
    tests++; if (oIllegal !== 1'b1 || oMemOp.dv !== 1'b0) begin fails++; $display("FAIL ld_f3: got ill=%b memdv=%b want 1 0", oIllegal, oMemOp.dv); end
    step;
  endtask

  task automatic test_illegal;
    sendOne(32'h00000000, 32'h300);
    tests++; if (oValid !== 1'b1 || oIllegal !== 1'b1) begin fails++; $display("FAIL zero_ill: got vld=%b ill=%b want 1 1", oValid, oIllegal); end
    tests++; if (oRegOp.dv !== 1'b0 || oMemOp.dv !== 1'b0 || oBranchOp.dv !== 1'b0 || oDecoded.imm !== '0) begin fails++;
      $display("FAIL zero_dv: got dv=%b%b%b imm=%h want 000 0", oRegOp.dv, oMemOp.dv, oBranchOp.dv, oDecoded.imm); end
    step;
  endtask

  task automatic test_back_to_back;
    int nextIdx = 0;
    int received = 0;
    logic acc;
    iReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      iValid = 1'b1;
      iInst  = ((nextIdx + 1) << 20) | ((nextIdx + 1) << 7) | 32'h13;
      iCurPc = 32'h1000 + 4 * nextIdx;
      #1;
      acc = oReady;
      step;
      if (acc) nextIdx++;
    end
    tests++; if (nextIdx != 2 || oReady !== 1'b0) begin fails++; $display("FAIL stall_accepts: got %0d rdy=%b want 2 0", nextIdx, oReady); end
    tests++; if (oValid !== 1'b1 || oDecoded.curPc !== 32'h1000) begin fails++;
      $display("FAIL stall_hold: got vld=%b pc=%h want 1 1000", oValid, oDecoded.curPc); end
    iReady = 1'b1;
    for (int c = 0; c < 40 && received < 5; c++) begin
      iValid = (nextIdx < 5);
      iInst  = ((nextIdx + 1) << 20) | ((nextIdx + 1) << 7) | 32'h13;
      iCurPc = 32'h1000 + 4 * nextIdx;
      #1;
      if (oValid) begin
        tests++; if (oDecoded.curPc !== 32'h1000 + 4 * received || oDecoded.imm !== received + 1) begin fails++;
          $display("FAIL order_%0d: got pc=%h imm=%h want %h %h", received, oDecoded.curPc, oDecoded.imm, 32'h1000 + 4 * received, received + 1); end
        received++;
      end
      acc = iValid && oReady;
      step;
      if (acc) nextIdx++;
    end
    iValid = 1'b0;
    tests++; if (received != 5 || nextIdx != 5) begin fails++; $display("FAIL drain_count: got rx=%0d tx=%0d want 5 5", received, nextIdx); end
    tests++; if (oValid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b want 0", oValid); end
  endtask

  task automatic test_flush;
    int seen = 0;
    iReady = 1'b0; iValid = 1'b1; iInst = 32'h00100093;
    iCurPc = 32'h2000; step;
    iCurPc = 32'h2004; step;
    iCurPc = 32'h2008; iFlush = 1'b1; iReady = 1'b1;
    #1;
    tests++; if (oValid !== 1'b1 || oDecoded.curPc !== 32'h2000) begin fails++;
      $display("FAIL flush_consume: got vld=%b pc=%h want 1 2000", oValid, oDecoded.curPc); end
    step;
    iFlush = 1'b0; iValid = 1'b0;
    tests++; if (oValid !== 1'b0) begin fails++; $display("FAIL flush_clear: got %b want 0", oValid); end
    for (int c = 0; c < 6; c++) begin
      if (oValid) seen++;
      step;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL flush_ghost: got %0d want 0", seen); end
    sendOne(32'h00100093, 32'h200C);
    tests++; if (oValid !== 1'b1 || oDecoded.curPc !== 32'h200C) begin fails++;
      $display("FAIL flush_after: got vld=%b pc=%h want 1 200c", oValid, oDecoded.curPc); end
    step;
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    iReady = 1'b0; iValid = 1'b1; iInst = 32'h00100093; iCurPc = 32'h3000;
    step;
    iRst = 1'b1; iFlush = 1'b1; iReady = 1'b1; iCurPc = 32'h3004;
    step;
    iRst = 1'b0; iFlush = 1'b0; iValid = 1'b0;
    tests++; if (oValid !== 1'b0 || oReady !== 1'b1) begin fails++; $display("FAIL rstmid: got vld=%b rdy=%b want 0 1", oValid, oReady); end
    for (int c = 0; c < 4; c++) begin
      if (oValid) seen++;
      step;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL rstmid_ghost: got %0d want 0", seen); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_shift;
    test_branch;
    test_misc;
    test_illegal;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/inst_decode_pipe.md
INST_DECODE_PIPE -- requirements
Module: inst_decode_pipe

Interface
REQ-001 SHALL have parameter pXLEN, default 32: data/PC width; only 32 is legal.
REQ-002 SHALL have parameter pStages, default 2: register stages, legal range 1..3.
REQ-003 SHALL have parameter pFenceAsNop, default 1: 1 decodes FENCE as NOP; 0 flags it illegal.
REQ-004 SHALL have port iClk, input, 1: the single clock.
REQ-005 SHALL have port iRst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port iInst, input, pXLEN: instruction word.
REQ-007 SHALL have port iCurPc, input, pXLEN: PC of iInst.
REQ-008 SHALL have port iValid, input, 1: iInst/iCurPc valid.
REQ-009 SHALL have port oReady, output, 1: accept slot free.
REQ-010 SHALL have port iFlush, input, 1: drop all in-flight instructions.
REQ-011 SHALL have port oValid, output, 1: decoded outputs valid.
REQ-012 SHALL have port iReady, input, 1: downstream consumes.
REQ-013 SHALL have port oDecoded, output, tDecodedInst: fields, imm, curPc.
REQ-014 SHALL have ports oMemOp/oRegOp/oBranchOp, output, package structs: per-unit control.
REQ-015 SHALL have port oIllegal, output, 1: instruction not decodable.

Function
REQ-016 SHALL complete the handshake when valid and ready are both high in the same cycle, on both sides.
REQ-017 SHALL hold a valid bit per stage k; stage k loads when !valid_k or ready_{k+1}; oReady = ready of stage 0.
REQ-018 SHALL have latency exactly pStages cycles from accept to oValid when iReady is constantly high; throughput is 1 per cycle.
REQ-019 SHALL keep all outputs stable while oValid=1 and iReady=0; no drop, no duplicate, order preserved.
REQ-020 SHALL, on iFlush=1, clear all valid bits next cycle; a simultaneous input accept is discarded; a simultaneous output handshake still counts as consumed.
REQ-021 SHALL decode opcode/fields combinationally before stage 0; later stages carry payload only.
REQ-022 SHALL form the immediate from the instruction as follows:
- I: sign-extended [31:20].
- S: {[31:25],[11:7]} sign-extended.
- B: {[31],[7],[30:25],[11:8],0} sign-extended.
- U: {[31:12],12'b0}.
- J: {[31],[19:12],[20],[30:21],0} sign-extended.
- R/other: 0.
REQ-023 SHALL map OP-IMM funct3=101 to eShftRightArit when funct7[5]=1 and to eShftRight when funct7[5]=0.
REQ-024 SHALL set oIllegal=1 when any of the following holds: [1:0]!=2'b11; unknown opcode; R-type funct7 not in {0000000, 0100000}; 0100000 with funct3 not in {000, 101}; shift-imm funct7 invalid; branch funct3 in {010, 011}; load/store funct3 invalid; SYSTEM; FENCE when pFenceAsNop=0.
REQ-025 SHALL, when oIllegal=1, force memOp/regOp/branchOp dv=0 and imm=0 while oValid is still asserted.
REQ-026 SHALL decode FENCE with pFenceAsNop=1 as all dv=0 and oIllegal=0.
REQ-027 SHALL make LUI regOp: arith eNoOp, opImm=1.
REQ-028 SHALL make AUIPC regOp: arith eAdd, opImm=1, opPc=1.
REQ-029 SHALL make JAL/JALR regOp: arith eAdd, opPc=1, opConst=1; branchOp: eJal/eJalr with dv=1.

Reset
REQ-030 SHALL, on iRst=1 at a clock edge, clear all valid bits, so oValid=0 the next cycle.
REQ-031 SHALL, on iRst=1, zero all payload registers and oIllegal.
REQ-032 SHALL drive oReady=1 from the first cycle after reset.
REQ-033 SHALL abandon any in-flight instruction on reset mid-operation; no output handshake occurs in the reset cycle.
REQ-034 SHALL give iRst priority over iFlush and over input accept.

Structure
REQ-035 SHALL keep tOpcodeEnum, tArithEnum, tBranchEnum and the tDecoded* structs in corePckg, extended with a tImmFmt enum (I, S, B, U, J, NONE).
REQ-036 SHALL place the combinational decode in a package function decodeInst().
REQ-037 SHALL use one sub-module, dec_pipe_slice, holding one valid/ready register stage, generated pStages times.

Verification
REQ-038 SHALL check: pStages=2, input 0xFFF10093 (ADDI x1,x2,-1) -> oValid 2 cycles later; rd=1, rs1=2, imm=0xFFFFFFFF, eAdd, opRs1=1, opImm=1.
REQ-039 SHALL check: 0x40315093 -> eShftRightArit; 0x00315093 -> eShftRight; both imm[4:0]=3.
REQ-040 SHALL check: 0xFE000EE3 (BEQ x0,x0,-4) -> imm=0xFFFFFFFC, branchOp eEqual, dv=1.
REQ-041 SHALL check: iReady=0 for 5 cycles with 5 inputs offered -> oReady falls after pStages accepts; after release all outputs arrive in order, none lost.
REQ-042 SHALL check: iFlush=1 while iValid=1 with 2 in flight -> next cycle oValid=0; flushed and discarded words never appear.
REQ-043 SHALL check: 0x00000000 -> oIllegal=1, all dv=0, oValid=1.
